grf_mp: RTL

- Parametrised multi-port general register file, successor to the 2R/1W file.
- Provides NRD combinational read ports with write-through bypass and NWR write ports with fixed priority.
- Adds a per-register pending (scoreboard) bit: set on issue, cleared on writeback, for hazard stall logic.
- Sits in the decode stage; write ports are driven from the writeback stage.

---
 rtl/grf_mp_pkg.sv | 18 +
 rtl/grf_bypass_mux.sv | 43 ++++
 rtl/grf_mp.sv | 119 +++++++++++
 3 files changed

// File: rtl/grf_mp_pkg.sv
// Shared widths, index constants and default geometry for the grf_mp register file.
package grf_mp_pkg;

  // Architectural word width and register-index width.
  localparam int WORD_W     = 32;
  localparam int TYPE_REG_W = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [TYPE_REG_W-1:0] type_reg_t;

  // Index of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  // Default geometry for grf_mp.
  localparam int DEFAULT_DATA_W = WORD_W;
  localparam int DEFAULT_ADDR_W = TYPE_REG_W;

endpackage

// File: rtl/grf_bypass_mux.sv
// One read port of grf_mp: priority write-through bypass and busy masking.
module grf_bypass_mux
  import grf_mp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NWR    = 2
) (
  input  logic                  en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     stored,
  input  logic                  pending,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_busy
);

  logic nonzero;
  logic any_hit;

  assign nonzero = (rd_addr != ADDR_W'(REG_ZERO));

  // Later ports overwrite earlier matches, so the highest-index hit wins.
  always_comb begin
    rd_data = stored;
    any_hit = 1'b0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (en && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
        rd_data = wr_data[j*DATA_W +: DATA_W];
        any_hit = 1'b1;
      end
    end
    if (!nonzero) begin
      rd_data = '0;
      any_hit = 1'b0;
    end
  end

  assign rd_busy = nonzero & pending & ~any_hit;

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write-through bypass and a pending
// (scoreboard) bit per register. Optional write trace under GRF_TRACE_EN.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NWR*32-1:0]     wr_pc,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  // Next pending vector: writeback clears first, then issue sets.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)))
        pending_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en && (iss_addr != ADDR_W'(REG_ZERO)))
      pending_nxt[iss_addr] = 1'b1;
  end

  // Population count of the next pending vector.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
  end

  // Register storage; ascending port order lets the higher port win a conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (en) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)))
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Pending bits and their count, updated together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else if (en) begin
      pending  <= pending_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      grf_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NWR    (NWR)
      ) u_mux (
        .en      (en),
        .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
        .stored  (regs[rd_addr[k*ADDR_W +: ADDR_W]]),
        .pending (pending[rd_addr[k*ADDR_W +: ADDR_W]]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data[k*DATA_W +: DATA_W]),
        .rd_busy (rd_busy[k])
      );
    end
  endgenerate

`ifdef GRF_TRACE_EN
  // Print each committed write once; a write shadowed by a higher port is skipped.
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          logic shadowed;
          shadowed = 1'b0;
          for (int unsigned h = j + 1; h < NWR; h++)
            if (wr_en[h] && (wr_addr[h*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
              shadowed = 1'b1;
          if (!shadowed)
            $display("%d@%h: $%d <= %h", $time, wr_pc[j*32 +: 32],
                     wr_addr[j*ADDR_W +: ADDR_W], wr_data[j*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif

endmodule
